iir_coeff_loader: RTL and testbench

- Writer side of the biquad coefficient interface: accepts coefficient writes over a valid/ready config port into a shadow bank.
- Drives the active b0/b1/b2/a1/a2 buses for a cascade of NUM_SECTIONS second-order sections.
- The shadow-to-active swap is atomic and happens only on a sample boundary (sample_strobe), so no section ever runs a sample with a mixed old/new coefficient set.

---
 rtl/iir_coeff_if.sv | 24 ++
 rtl/iir_coeff_loader.sv | 101 ++++++++++
 tb/tb_iir_coeff_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/iir_coeff_if.sv
// Coefficient write port of the biquad loader: valid/ready write plus commit request.
// The master side issues writes and commits. The slave side (the loader) returns ready and the write-error pulse.
interface iir_coeff_if #(
  parameter int SECT_IDX_WIDTH = 2,
  parameter int COEFF_WIDTH    = 32
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [SECT_IDX_WIDTH-1:0] cfg_sect;
  logic [2:0]                cfg_sel;
  logic [COEFF_WIDTH-1:0]    cfg_data;
  logic                      cfg_commit;
  logic                      cfg_err;

  modport master (
    output cfg_valid, cfg_sect, cfg_sel, cfg_data, cfg_commit,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_sect, cfg_sel, cfg_data, cfg_commit,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/iir_coeff_loader.sv
// Shadow/active coefficient banks for a biquad cascade; commit is atomic on a sample strobe.
// Writes land one edge after acceptance; coeff_* swap on the strobe edge; cfg_ready is low while a commit is in flight.
module iir_coeff_loader #(
  parameter int COEFF_WIDTH    = 32,
  parameter int NUM_SECTIONS   = 4,
  parameter int SECT_IDX_WIDTH = 2,
  parameter int SCALE_SHIFT    = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  iir_coeff_if.slave                          cfg,
  input  logic                                sample_strobe,
  output logic [NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_b0,
  output logic [NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_b1,
  output logic [NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_b2,
  output logic [NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_a1,
  output logic [NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_a2,
  output logic                                commit_pending,
  output logic                                commit_done
);

  typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;
  typedef logic [COEFF_WIDTH-1:0] coeff_t;

  localparam coeff_t UNITY = COEFF_WIDTH'(1) << SCALE_SHIFT;

  state_t state;
  coeff_t shadow [NUM_SECTIONS][5];
  coeff_t active [NUM_SECTIONS][5];

  logic wr_ok;
  assign wr_ok = (cfg.cfg_sel <= 3'd4) && (int'(cfg.cfg_sect) < NUM_SECTIONS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cfg.cfg_ready  <= 1'b1;
      cfg.cfg_err    <= 1'b0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        for (int c = 0; c < 5; c++) begin
          shadow[s][c] <= (c == 0) ? UNITY : '0;
          active[s][c] <= (c == 0) ? UNITY : '0;
        end
      end
    end else begin
      cfg.cfg_err <= 1'b0;
      commit_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            cfg.cfg_err <= !wr_ok;
            for (int s = 0; s < NUM_SECTIONS; s++) begin
              for (int c = 0; c < 5; c++) begin
                if (wr_ok && cfg.cfg_sect == SECT_IDX_WIDTH'(s) && cfg.cfg_sel == 3'(c))
                  shadow[s][c] <= cfg.cfg_data;
              end
            end
          end
          // A strobe seen here is deliberately ignored, even alongside cfg_commit.
          if (cfg.cfg_commit) begin
            state          <= PENDING;
            cfg.cfg_ready  <= 1'b0;
            commit_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (sample_strobe) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
              for (int c = 0; c < 5; c++) begin
                active[s][c] <= shadow[s][c];
              end
            end
            state          <= DONE;
            commit_pending <= 1'b0;
            commit_done    <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          cfg.cfg_ready <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          cfg.cfg_ready  <= 1'b1;
          commit_pending <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SECTIONS; k++) begin : g_out
    assign coeff_b0[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k][0];
    assign coeff_b1[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k][1];
    assign coeff_b2[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k][2];
    assign coeff_a1[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k][3];
    assign coeff_a2[k*COEFF_WIDTH +: COEFF_WIDTH] = active[k][4];
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed plus random bench for iir_coeff_loader with three sections, so that an out-of-range section index is reachable.
module tb_iir_coeff_loader;
  localparam int CW = 32;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int FW = NS * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_strobe = 1'b0;
  logic [FW-1:0] coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2;
  logic commit_pending, commit_done;

  iir_coeff_if #(.SECT_IDX_WIDTH(SW), .COEFF_WIDTH(CW)) bus ();

  iir_coeff_loader #(.COEFF_WIDTH(CW), .NUM_SECTIONS(NS), .SECT_IDX_WIDTH(SW), .SCALE_SHIFT(20)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(bus.slave), .sample_strobe(sample_strobe),
    .coeff_b0(coeff_b0), .coeff_b1(coeff_b1), .coeff_b2(coeff_b2),
    .coeff_a1(coeff_a1), .coeff_a2(coeff_a2),
    .commit_pending(commit_pending), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the two banks as plain arrays, indexed [section][0=b0,1=b1,2=b2,3=a1,4=a2]
  logic [CW-1:0] m_sh  [NS][5];
  logic [CW-1:0] m_act [NS][5];

  function automatic void model_reset();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < 5; c++) begin
        m_sh[s][c]  = (c == 0) ? 32'h0010_0000 : 32'h0;
        m_act[s][c] = m_sh[s][c];
      end
  endfunction

  function automatic logic [FW-1:0] flat(int c);
    logic [FW-1:0] r;
    for (int s = 0; s < NS; s++) r[s*CW +: CW] = m_act[s][c];
    return r;
  endfunction

  task automatic chk(string tag, logic [FW-1:0] obs, logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".b0"}, coeff_b0, flat(0));
    chk({tag, ".b1"}, coeff_b1, flat(1));
    chk({tag, ".b2"}, coeff_b2, flat(2));
    chk({tag, ".a1"}, coeff_a1, flat(3));
    chk({tag, ".a2"}, coeff_a2, flat(4));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write issued from IDLE, optionally with commit and an (ignored) strobe in the same cycle
  task automatic wr(input int sect, input int sel, input logic [CW-1:0] data,
                    input bit commit, input bit strobe);
    bit bad;
    bus.cfg_valid  = 1'b1;
    bus.cfg_sect   = SW'(sect);
    bus.cfg_sel    = 3'(sel);
    bus.cfg_data   = data;
    bus.cfg_commit = commit;
    sample_strobe  = strobe;
    chk("wr_ready", FW'(bus.cfg_ready), FW'(1));
    tick();
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b0;
    sample_strobe  = 1'b0;
    bad = (sel > 4) || (sect >= NS);
    if (!bad) m_sh[sect][sel] = data;
    chk("wr_err", FW'(bus.cfg_err), FW'(bad));
    chk("wr_pending", FW'(commit_pending), FW'(commit));
  endtask

  task automatic commit_only();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  // Stays in PENDING for dly strobe-free cycles, then strobes and checks the swap and done pulse
  task automatic wait_commit(input int dly);
    for (int i = 0; i < dly; i++) begin
      chk("pend_hi", FW'(commit_pending), FW'(1));
      chk("pend_ready", FW'(bus.cfg_ready), FW'(0));
      check_all("pend_hold");
      tick();
    end
    chk("pend_hi", FW'(commit_pending), FW'(1));
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < 5; c++) m_act[s][c] = m_sh[s][c];
    check_all("swap");
    chk("done_hi", FW'(commit_done), FW'(1));
    chk("done_pend", FW'(commit_pending), FW'(0));
    chk("done_ready", FW'(bus.cfg_ready), FW'(0));
    tick();
    chk("done_lo", FW'(commit_done), FW'(0));
    chk("idle_ready", FW'(bus.cfg_ready), FW'(1));
  endtask

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_sect = '0; bus.cfg_sel = '0;
    bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state: pass-through coefficients and idle handshake
    check_all("reset");
    chk("rst_b0_s0", FW'(coeff_b0[31:0]), FW'(32'h0010_0000));
    chk("rst_ready", FW'(bus.cfg_ready), FW'(1));
    chk("rst_pending", FW'(commit_pending), FW'(0));
    chk("rst_done", FW'(commit_done), FW'(0));
    chk("rst_err", FW'(bus.cfg_err), FW'(0));

    // Uncommitted write never reaches the active bank, however many strobes pass
    wr(1, 3, 32'hFFE6_0000, 1'b0, 1'b0);
    wr(2, 4, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample_strobe = 1'b1; tick();
      sample_strobe = 1'b0; tick();
      chk("nocommit_done", FW'(commit_done), FW'(0));
    end
    chk("nocommit_a1_s1", FW'(coeff_a1[63:32]), FW'(0));
    check_all("nocommit");

    commit_only();
    wait_commit(4);
    chk("a1_s1_published", FW'(coeff_a1[63:32]), FW'(32'hFFE6_0000));

    // Write+commit+strobe together: write is included, that strobe is ignored
    wr(0, 2, 32'h0008_0000, 1'b1, 1'b1);
    chk("same_cycle_b2_old", FW'(coeff_b2[31:0]), FW'(0));
    wait_commit(2);
    chk("same_cycle_b2_new", FW'(coeff_b2[31:0]), FW'(32'h0008_0000));

    // Rejected writes: bad select and out-of-range section
    wr(1, 6, $urandom, 1'b0, 1'b0);
    tick();
    chk("err_single", FW'(bus.cfg_err), FW'(0));
    wr(3, 0, $urandom, 1'b0, 1'b0);
    wr(0, 4, $urandom, 1'b1, 1'b0);
    wait_commit(1);

    // Write held while busy is taken only once the loader is back in IDLE
    commit_only();
    bus.cfg_valid = 1'b1; bus.cfg_sect = 2'd2; bus.cfg_sel = 3'd1; bus.cfg_data = 32'h0000_1234;
    chk("busy_ready", FW'(bus.cfg_ready), FW'(0));
    tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < 5; c++) m_act[s][c] = m_sh[s][c];
    check_all("busy_swap");
    chk("busy_done", FW'(commit_done), FW'(1));
    chk("busy_err", FW'(bus.cfg_err), FW'(0));
    begin
      int waited = 0;
      while (bus.cfg_ready !== 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      chk("busy_ready_timeout", FW'(waited < 10), FW'(1));
    end
    tick();
    bus.cfg_valid = 1'b0;
    m_sh[2][1] = 32'h0000_1234;
    chk("busy_accept_err", FW'(bus.cfg_err), FW'(0));
    commit_only();
    wait_commit(3);
    chk("busy_b1_s2", FW'(coeff_b1[95:64]), FW'(32'h0000_1234));

    // Random writes (including invalid indices) and commits against the model
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++)
        wr($urandom_range(0, 3), $urandom_range(0, 7), $urandom, w == n - 1, 1'($urandom_range(0, 1)));
      wait_commit($urandom_range(0, 4));
    end

    // Reset while PENDING discards the commit and restores pass-through
    wr(0, 0, $urandom, 1'b0, 1'b0);
    wr(1, 2, $urandom, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("midrst");
    chk("midrst_pending", FW'(commit_pending), FW'(0));
    chk("midrst_ready", FW'(bus.cfg_ready), FW'(1));
    chk("midrst_done", FW'(commit_done), FW'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample_strobe = 1'($urandom_range(0, 1));
      tick();
      chk("postrst_done", FW'(commit_done), FW'(0));
      chk("postrst_pending", FW'(commit_pending), FW'(0));
    end
    sample_strobe = 1'b0;
    check_all("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
